// File: rtl/control_sequencer.sv
// Hardwired control sequencer for the DataPath. Steps through the fetch/execute
// sequence T0..T5 for 3-register ALU instructions and emits every DataPath strobe.
//
// Ports:
//   clock, clear       single rising-edge clock; asynchronous active-high reset
//   IR                 instruction register contents (opcode = IR[31:27])
//   MD_ready           memory read data valid (only looked at in T1)
//   step               single-step advance (only with CU_SINGLE_STEP_EN defined)
//   PCout .. Rout      DataPath bus-driver / register-enable strobes
//   alu_op             latched opcode, driven only in T4
//   instr_done         one-cycle pulse in T5
//   illegal            one-cycle pulse in T3 on an unsupported opcode
//   run                high while sequencing
//   err                sticky memory-timeout flag, cleared only by clear
//
// Optional feature: define CU_SINGLE_STEP_EN to add the step input and a STEP_WAIT
// state after T5 that holds until step is seen high.
module control_sequencer #(
  parameter int unsigned IR_W        = 32,
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter logic [4:0]  HALT_OPCODE = 5'b11011
) (
  input  logic            clock,
  input  logic            clear,
  input  logic [IR_W-1:0] IR,
  input  logic            MD_ready,
`ifdef CU_SINGLE_STEP_EN
  input  logic            step,
`endif
  output logic            PCout,
  output logic            Zlowout,
  output logic            MDRout,
  output logic            MARin,
  output logic            Zin,
  output logic            PCin,
  output logic            MDRin,
  output logic            IRin,
  output logic            Yin,
  output logic            IncPC,
  output logic            Read,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic [4:0]      alu_op,
  output logic            instr_done,
  output logic            illegal,
  output logic            run,
  output logic            err
);

  localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    StRst, StT0, StT1, StT2, StT3, StT4, StT5, StHalt, StErr
`ifdef CU_SINGLE_STEP_EN
    , StStepWait
`endif
  } state_e;

  state_e          state_q, state_d;
  logic [4:0]      op_q, op_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [4:0] opcode;
  logic       op_halt, op_alu;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];
  // Halt takes priority in case HALT_OPCODE is ever set inside the ALU range.
  assign op_halt   = (opcode == HALT_OPCODE);
  assign op_alu    = !op_halt && (opcode >= 5'd3) && (opcode <= 5'd11);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    case (state_q)
      StRst: state_d = StT0;
      StT0: begin
        cnt_d   = '0;
        state_d = StT1;
      end
      StT1: begin
        // Data arriving on the timeout cycle still wins over the error.
        if (MD_ready) begin
          state_d = StT2;
        end else if (cnt_q == CntLast) begin
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StT2: state_d = StT3;
      StT3: begin
        op_d = opcode;
        if (op_halt)     state_d = StHalt;
        else if (op_alu) state_d = StT4;
        else             state_d = StT0;
      end
      StT4: state_d = StT5;
`ifdef CU_SINGLE_STEP_EN
      StT5:       state_d = StStepWait;
      StStepWait: if (step) state_d = StT0;
`else
      StT5: state_d = StT0;
`endif
      StHalt: state_d = StHalt;
      StErr:  state_d = StErr;
      default: state_d = StRst;
    endcase
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q <= StRst;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  // Strobes decode from the registered state; T3 also looks at the freshly loaded IR.
  always_comb begin
    PCout      = 1'b0;
    Zlowout    = 1'b0;
    MDRout     = 1'b0;
    MARin      = 1'b0;
    Zin        = 1'b0;
    PCin       = 1'b0;
    MDRin      = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    IncPC      = 1'b0;
    Read       = 1'b0;
    Gra        = 1'b0;
    Grb        = 1'b0;
    Grc        = 1'b0;
    Rin        = 1'b0;
    Rout       = 1'b0;
    alu_op     = 5'd0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    run        = 1'b0;
    err        = 1'b0;
    case (state_q)
      StT0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
        run   = 1'b1;
      end
      StT1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        run     = 1'b1;
      end
      StT2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
        run    = 1'b1;
      end
      StT3: begin
        run = 1'b1;
        if (op_alu) begin
          Grb  = 1'b1;
          Rout = 1'b1;
          Yin  = 1'b1;
        end else if (!op_halt) begin
          illegal = 1'b1;
        end
      end
      StT4: begin
        Grc    = 1'b1;
        Rout   = 1'b1;
        Zin    = 1'b1;
        alu_op = op_q;
        run    = 1'b1;
      end
      StT5: begin
        Zlowout    = 1'b1;
        Gra        = 1'b1;
        Rin        = 1'b1;
        instr_done = 1'b1;
        run        = 1'b1;
      end
`ifdef CU_SINGLE_STEP_EN
      StStepWait: run = 1'b1;
`endif
      StErr:   err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer: walks instruction sequences cycle by
// cycle and compares the strobe and status vectors to hand-written expectations.
module tb_control_sequencer;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic [31:0] IR = 32'h0;
  logic        MD_ready = 1'b0;
  logic        step = 1'b1;
  logic PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read;
  logic Gra, Grb, Grc, Rin, Rout, instr_done, illegal, run, err;
  logic [4:0] alu_op;

  int checks = 0;
  int errors = 0;

`ifdef CU_SINGLE_STEP_EN
  localparam bit StepEn = 1'b1;
`else
  localparam bit StepEn = 1'b0;
`endif

  control_sequencer #(.IR_W(32), .MEM_TIMEOUT(16), .HALT_OPCODE(5'b11011)) dut (
    .clock(clock), .clear(clear), .IR(IR), .MD_ready(MD_ready),
`ifdef CU_SINGLE_STEP_EN
    .step(step),
`endif
    .PCout(PCout), .Zlowout(Zlowout), .MDRout(MDRout), .MARin(MARin), .Zin(Zin),
    .PCin(PCin), .MDRin(MDRin), .IRin(IRin), .Yin(Yin), .IncPC(IncPC), .Read(Read),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .alu_op(alu_op),
    .instr_done(instr_done), .illegal(illegal), .run(run), .err(err)
  );

  always #5 clock = ~clock;

  // Bit order: PCout Zlowout MDRout MARin Zin PCin MDRin IRin Yin IncPC Read Gra Grb Grc Rin Rout
  logic [15:0] strb;
  logic [8:0]  stat;
  assign strb = {PCout, Zlowout, MDRout, MARin, Zin, PCin, MDRin, IRin, Yin, IncPC, Read,
                 Gra, Grb, Grc, Rin, Rout};
  assign stat = {alu_op, instr_done, illegal, run, err};

  localparam int CRst = 0, CT0 = 1, CT1 = 2, CT2 = 3, CT3 = 4, CT4 = 5, CT5 = 6;
  localparam int CT3Ill = 7, CT3Halt = 8, CHalt = 9, CErr = 10, CStep = 11;

  function automatic logic [15:0] exp_strb(input int c);
    case (c)
      CT0:     return 16'h9840;
      CT1:     return 16'h4620;
      CT2:     return 16'h2100;
      CT3:     return 16'h0089;
      CT4:     return 16'h0805;
      CT5:     return 16'h4012;
      default: return 16'h0000;
    endcase
  endfunction

  // {alu_op, instr_done, illegal, run, err}
  function automatic logic [8:0] exp_stat(input int c, input logic [4:0] op);
    case (c)
      CT0, CT1, CT2, CT3, CT3Halt, CStep: return 9'b00000_0010;
      CT3Ill:  return 9'b00000_0110;
      CT4:     return {op, 4'b0010};
      CT5:     return 9'b00000_1010;
      CErr:    return 9'b00000_0001;
      default: return 9'b00000_0000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (strb !== 16'h0 || stat !== 9'h0) begin
        errors++;
        $display("FAIL reset cyc %0d: strb=%h stat=%b, required 0000/000000000", k, strb, stat);
      end
      tick();
    end
    @(negedge clock);
    clear = 1'b0;
    tick();
    checks++;
    if (strb !== exp_strb(CT0) || stat !== exp_stat(CT0, 5'd0)) begin
      errors++;
      $display("FAIL reset_to_t0: strb=%h stat=%b, required %h/%b", strb, stat,
               exp_strb(CT0), exp_stat(CT0, 5'd0));
    end
  endtask

  task automatic test_basic_alu();
    int seq [7] = '{CT0, CT1, CT2, CT3, CT4, CT5, CT0};
    IR = 32'h28918000;
    MD_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (strb !== exp_strb(seq[k])) begin
        errors++;
        $display("FAIL basic_alu strb cyc %0d: got %h, required %h", k, strb, exp_strb(seq[k]));
      end
      checks++;
      if (stat !== exp_stat(seq[k], 5'd5)) begin
        errors++;
        $display("FAIL basic_alu stat cyc %0d: got %b, required %b", k, stat,
                 exp_stat(seq[k], 5'd5));
      end
      if (k < 6) begin
        tick();
        if (StepEn && seq[k] == CT5) begin
          checks++;
          if (strb !== 16'h0 || stat !== exp_stat(CStep, 5'd0)) begin
            errors++;
            $display("FAIL basic_alu step_wait: strb=%h stat=%b", strb, stat);
          end
          tick();
        end
      end
    end
  endtask

  task automatic test_mem_wait();
    int seq [10] = '{CT0, CT1, CT1, CT1, CT1, CT2, CT3, CT4, CT5, CT0};
    IR = 32'h28918000;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (strb !== exp_strb(seq[k]) || stat !== exp_stat(seq[k], 5'd5)) begin
        errors++;
        $display("FAIL mem_wait cyc %0d: strb=%h stat=%b, required %h/%b", k, strb, stat,
                 exp_strb(seq[k]), exp_stat(seq[k], 5'd5));
      end
      MD_ready = (k >= 4);  // data shows up in the fourth T1 cycle
      if (k < 9) begin
        tick();
        if (StepEn && seq[k] == CT5) tick();
      end
    end
    MD_ready = 1'b1;
  endtask

  task automatic test_timeout();
    int c;
    IR = 32'h28918000;
    MD_ready = 1'b0;
    for (int k = 0; k < 21; k++) begin
      c = (k == 0) ? CT0 : (k <= 16) ? CT1 : CErr;
      checks++;
      if (strb !== exp_strb(c) || stat !== exp_stat(c, 5'd0)) begin
        errors++;
        $display("FAIL timeout cyc %0d: strb=%h stat=%b, required %h/%b", k, strb, stat,
                 exp_strb(c), exp_stat(c, 5'd0));
      end
      if (k < 20) tick();
    end
    MD_ready = 1'b1;  // late data must not pull it out of ERR
    tick();
    checks++;
    if (stat !== exp_stat(CErr, 5'd0)) begin
      errors++;
      $display("FAIL timeout_sticky: stat=%b, required %b", stat, exp_stat(CErr, 5'd0));
    end
    clear = 1'b1;
    #1;
    checks++;
    if (strb !== 16'h0 || stat !== 9'h0) begin
      errors++;
      $display("FAIL timeout_clear: strb=%h stat=%b, required zeros", strb, stat);
    end
    @(negedge clock);
    clear = 1'b0;
    tick();
    checks++;
    if (strb !== exp_strb(CT0) || stat !== exp_stat(CT0, 5'd0)) begin
      errors++;
      $display("FAIL timeout_restart: strb=%h stat=%b, required %h", strb, stat, exp_strb(CT0));
    end
  endtask

  task automatic test_illegal();
    int seq [5] = '{CT0, CT1, CT2, CT3Ill, CT0};
    IR = 32'hF8000000;
    MD_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (strb !== exp_strb(seq[k]) || stat !== exp_stat(seq[k], 5'd0)) begin
        errors++;
        $display("FAIL illegal cyc %0d: strb=%h stat=%b, required %h/%b", k, strb, stat,
                 exp_strb(seq[k]), exp_stat(seq[k], 5'd0));
      end
      if (k < 4) tick();
    end
  endtask

  task automatic test_halt_and_clear();
    int hseq [8] = '{CT0, CT1, CT2, CT3Halt, CHalt, CHalt, CHalt, CHalt};
    int aseq [5] = '{CT0, CT1, CT2, CT3, CT4};
    IR = 32'hD8000000;
    MD_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (strb !== exp_strb(hseq[k]) || stat !== exp_stat(hseq[k], 5'd0)) begin
        errors++;
        $display("FAIL halt cyc %0d: strb=%h stat=%b, required %h/%b", k, strb, stat,
                 exp_strb(hseq[k]), exp_stat(hseq[k], 5'd0));
      end
      if (k < 7) tick();
    end
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    IR = 32'h28918000;
    tick();
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (strb !== exp_strb(aseq[k]) || stat !== exp_stat(aseq[k], 5'd5)) begin
        errors++;
        $display("FAIL halt_rerun cyc %0d: strb=%h stat=%b, required %h/%b", k, strb, stat,
                 exp_strb(aseq[k]), exp_stat(aseq[k], 5'd5));
      end
      if (k < 4) tick();
    end
    // Mid-T4 abort: outputs must drop without waiting for a clock edge.
    #1;
    clear = 1'b1;
    #1;
    checks++;
    if (strb !== 16'h0 || stat !== 9'h0) begin
      errors++;
      $display("FAIL async_clear: strb=%h stat=%b, required zeros", strb, stat);
    end
    #2;
    clear = 1'b0;
    #1;
    checks++;
    if (strb !== 16'h0 || stat !== 9'h0) begin
      errors++;
      $display("FAIL clear_rst_hold: strb=%h stat=%b, required zeros", strb, stat);
    end
    tick();
    checks++;
    if (strb !== exp_strb(CT0) || stat !== exp_stat(CT0, 5'd0)) begin
      errors++;
      $display("FAIL clear_to_t0: strb=%h stat=%b, required %h", strb, stat, exp_strb(CT0));
    end
  endtask

  task automatic test_single_step();
`ifdef CU_SINGLE_STEP_EN
    int seq [12] = '{CT0, CT1, CT2, CT3, CT4, CT5, CStep, CStep, CStep, CStep, CStep, CT0};
    IR = 32'h28918000;
    MD_ready = 1'b1;
    step = 1'b0;
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (strb !== exp_strb(seq[k]) || stat !== exp_stat(seq[k], 5'd5)) begin
        errors++;
        $display("FAIL single_step cyc %0d: strb=%h stat=%b, required %h/%b", k, strb, stat,
                 exp_strb(seq[k]), exp_stat(seq[k], 5'd5));
      end
      if (k == 10) step = 1'b1;
      if (k < 11) tick();
    end
`endif
  endtask

  initial begin
    #1;
    test_reset();
    test_basic_alu();
    test_mem_wait();
    test_timeout();
    test_illegal();
    test_halt_and_clear();
    test_single_step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
